// File: rtl/iir_pkg.sv
// Shared Q-format definitions for the iir low-pass filter and its inverse.
// Both blocks size their datapaths from these constants.
package iir_pkg;

    localparam int width_c = 10;
    localparam int frac_c  = 4;
    localparam int shift_c = 2;

    localparam int in_w   = width_c + frac_c;
    localparam int diff_w = in_w + 1;
    localparam int sum_w  = in_w + 2 + shift_c;

    // Clamp v into the signed range of a w-bit integer.
    function automatic logic signed [sum_w-1:0] sat_signed(
        input logic signed [sum_w-1:0] v,
        input int                      w
    );
        logic signed [sum_w-1:0] lo;
        logic signed [sum_w-1:0] hi;
        logic signed [sum_w-1:0] r;
        lo = -(sum_w'(1) <<< (w - 1));
        hi = ~lo;
        r  = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/elastic.sv
// One-entry valid/ready output register; a new word may replace the held
// word in the same cycle it is consumed.
module elastic
    import iir_pkg::*;
#(
    parameter int width_p = width_c
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic               r_valid;
    logic [width_p-1:0] r_data;
    logic               w_ready;
    logic               w_load;

    assign w_ready = ~r_valid | ready_i;
    assign w_load  = valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: rtl/iir_inv.sv
// Inverse first-order low-pass: rebuilds x[n] from the filter state y[n]
// as y[n-1] + (y[n]-y[n-1]) * 2^shift_p, rounded and saturated.
module iir_inv
    import iir_pkg::*;
#(
    parameter int width_p = width_c,
    parameter int frac_p  = frac_c,
    parameter int shift_p = shift_c
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    input  logic signed [width_p+frac_p-1:0]  data_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic signed [width_p-1:0]         data_o,
    input  logic                              ready_i,
    output logic                              sat_o
);

    logic signed [in_w-1:0]           w_y;
    logic signed [in_w-1:0]           r_yprev;
    logic signed [diff_w-1:0]         w_diff;
    logic signed [diff_w+shift_p-1:0] w_scaled;
    logic signed [sum_w-1:0]          w_sum;
    logic signed [sum_w-1:0]          w_rnd;
    logic signed [sum_w-1:0]          w_sat;
    logic signed [width_p-1:0]        w_res;
    logic                             w_clip;
    logic                             w_ready;
    logic                             w_fire;
    logic                             r_sat;

    assign w_y      = data_i;
    assign w_diff   = diff_w'(w_y) - diff_w'(r_yprev);
    assign w_scaled = (diff_w + shift_p)'(w_diff) <<< shift_p;
    assign w_sum    = sum_w'(r_yprev) + sum_w'(w_scaled);

    // Round half up; with no fractional bits there is nothing to round.
    if (frac_p > 0) begin : g_round
        assign w_rnd = (w_sum + (sum_w'(1) <<< (frac_p - 1))) >>> frac_p;
    end else begin : g_trunc
        assign w_rnd = w_sum;
    end

    assign w_sat  = sat_signed(w_rnd, width_p);
    assign w_clip = (w_sat != w_rnd);
    assign w_res  = w_sat[width_p-1:0];
    assign w_fire = valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_yprev <= '0;
            r_sat   <= 1'b0;
        end else if (w_fire) begin
            r_yprev <= w_y;
            if (w_clip) begin
                r_sat <= 1'b1;
            end
        end
    end

    elastic #(
        .width_p (width_p)
    ) u_out (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (w_res),
        .ready_o (w_ready),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    assign ready_o = w_ready;
    assign sat_o   = r_sat;

endmodule

// File: tb/tb_iir_inv.sv
// Bench for iir_inv: directed scenarios plus randomized traffic against
// an arithmetic reference of the inverse recurrence and a golden filter.
module tb_iir_inv;

    localparam int W = 10;
    localparam int F = 4;
    localparam int S = 2;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    valid_i = 1'b0;
    logic                    ready_i = 1'b1;
    logic signed [W+F-1:0]   data_i = '0;
    logic                    ready_o;
    logic                    valid_o;
    logic signed [W-1:0]     data_o;
    logic                    sat_o;

    int n_pass  = 0;
    int n_total = 0;
    int m_yprev = 0;

    always #5 clk = ~clk;

    iir_inv #(
        .width_p (W),
        .frac_p  (F),
        .shift_p (S)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .sat_o   (sat_o)
    );

    function automatic int ref_raw(int yp, int y);
        int s;
        s = yp + (y - yp) * (1 << S);
        return (s + (1 << (F - 1))) >>> F;
    endfunction

    function automatic int ref_x(int yp, int y);
        int r;
        r = ref_raw(yp, y);
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        m_yprev = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_total++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
        else n_pass++;
        n_total++;
        if (data_o !== 10'sd0) $display("FAIL reset_data: got %0d want 0", data_o);
        else n_pass++;
        n_total++;
        if (sat_o !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat_o);
        else n_pass++;
        n_total++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o);
        else n_pass++;
    endtask

    task automatic test_step();
        int ys[3] = '{400, 700, 925};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 14'(ys[i]);
            @(negedge clk);
            valid_i = 1'b0;
            n_total++;
            if (valid_o !== 1'b1 || data_o !== 10'sd100)
                $display("FAIL step[%0d]: valid %b data %0d want valid 1 data 100",
                         i, valid_o, data_o);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int ys[3] = '{8176, -8192, -8192};
        int xs[3] = '{511, -512, -512};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 14'(ys[i]);
            @(negedge clk);
            valid_i = 1'b0;
            n_total++;
            if (data_o !== 10'(xs[i]))
                $display("FAIL sat_data[%0d]: got %0d want %0d", i, data_o, xs[i]);
            else n_pass++;
            n_total++;
            if (sat_o !== 1'b1)
                $display("FAIL sat_flag[%0d]: got %b want 1", i, sat_o);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int yv[6];
        int held;
        for (int k = 0; k < 6; k++) yv[k] = int'($urandom_range(16383)) - 8192;
        apply_reset();
        held = ref_x(0, yv[0]);
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 14'(yv[0]);
        #1;
        n_total++;
        if (ready_o !== 1'b1) $display("FAIL bp_first_ready: got %b want 1", ready_o);
        else n_pass++;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            data_i = 14'(yv[k]);
            #1;
            n_total++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 10'(held))
                $display("FAIL bp_stall[%0d]: ready %b valid %b data %0d want 0 1 %0d",
                         k, ready_o, valid_o, data_o, held);
            else n_pass++;
        end
        @(negedge clk);
        ready_i = 1'b1;
        data_i  = 14'(yv[5]);
        #1;
        n_total++;
        if (ready_o !== 1'b1 || data_o !== 10'(held))
            $display("FAIL bp_release: ready %b data %0d want 1 %0d", ready_o, data_o, held);
        else n_pass++;
        @(negedge clk);
        valid_i = 1'b0;
        n_total++;
        if (valid_o !== 1'b1 || data_o !== 10'(ref_x(yv[0], yv[5])))
            $display("FAIL bp_next: valid %b data %0d want 1 %0d",
                     valid_o, data_o, ref_x(yv[0], yv[5]));
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (valid_o !== 1'b0) $display("FAIL bp_drain: valid %b want 0", valid_o);
        else n_pass++;
        m_yprev = yv[5];
    endtask

    task automatic test_throughput();
        int fy = 0;
        int xs[$];
        int x;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            x  = int'($urandom_range(1023)) - 512;
            fy = fy + ((x * 16 - fy) >>> S);
            xs.push_back(x);
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 14'(fy);
            if (i > 0) begin
                n_total++;
                if (valid_o !== 1'b1 || data_o !== 10'(xs[i-1])) begin
                    if (bad < 10)
                        $display("FAIL thru[%0d]: valid %b data %0d want 1 %0d",
                                 i - 1, valid_o, data_o, xs[i-1]);
                    bad++;
                end else n_pass++;
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        n_total++;
        if (valid_o !== 1'b1 || data_o !== 10'(xs[999]))
            $display("FAIL thru_last: valid %b data %0d want 1 %0d", valid_o, data_o, xs[999]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 14'(8176);
        @(negedge clk);
        valid_i = 1'b0;
        n_total++;
        if (valid_o !== 1'b1 || sat_o !== 1'b1)
            $display("FAIL rm_pending: valid %b sat %b want 1 1", valid_o, sat_o);
        else n_pass++;
        reset_n = 1'b0;
        valid_i = 1'b1;
        data_i  = 14'(400);
        @(negedge clk);
        reset_n = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        n_total++;
        if (valid_o !== 1'b0 || sat_o !== 1'b0)
            $display("FAIL rm_cleared: valid %b sat %b want 0 0", valid_o, sat_o);
        else n_pass++;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 14'(400);
        @(negedge clk);
        valid_i = 1'b0;
        n_total++;
        if (valid_o !== 1'b1 || data_o !== 10'sd100)
            $display("FAIL rm_first: valid %b data %0d want 1 100", valid_o, data_o);
        else n_pass++;
        m_yprev = 400;
    endtask

    task automatic test_rounding();
        int ys[2] = '{2, 0};
        int xs[2] = '{1, 0};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 14'(ys[i]);
            @(negedge clk);
            valid_i = 1'b0;
            n_total++;
            if (data_o !== 10'(xs[i]))
                $display("FAIL round[%0d]: got %0d want %0d", i, data_o, xs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_traffic();
        int q[$];
        int y;
        int exp_v;
        bit exp_sat = 1'b0;
        int bad = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            y       = int'($urandom_range(16383)) - 8192;
            valid_i = ($urandom_range(3) != 0);
            ready_i = ($urandom_range(2) != 0);
            data_i  = 14'(y);
            #1;
            if (valid_o === 1'b1 && ready_i) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 9999;
                n_total++;
                if (exp_v == 9999 || data_o !== 10'(exp_v)) begin
                    if (bad < 10)
                        $display("FAIL rand_out[%0d]: got %0d want %0d", c, data_o, exp_v);
                    bad++;
                end else n_pass++;
            end
            if (valid_i && ready_o === 1'b1) begin
                q.push_back(ref_x(m_yprev, y));
                if (ref_raw(m_yprev, y) != ref_x(m_yprev, y)) exp_sat = 1'b1;
                m_yprev = y;
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (valid_o === 1'b1) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 9999;
                n_total++;
                if (exp_v == 9999 || data_o !== 10'(exp_v))
                    $display("FAIL rand_drain: got %0d want %0d", data_o, exp_v);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++;
        if (q.size() != 0) $display("FAIL rand_lost: %0d outputs missing, want 0", q.size());
        else n_pass++;
        n_total++;
        if (sat_o !== exp_sat) $display("FAIL rand_sat: got %b want %b", sat_o, exp_sat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_saturation();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_rounding();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
